alu_arbiter: RTL and testbench

//  Shares the single ALU (alu: A, B, 5-bit opcode -> Y, zero) between two requesters
//  (port 0: main pipeline, port 1: address/aux unit) via valid/ready handshakes.

---
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external ALU; one op in flight, result valid 2 cycles after grant.
// Response is held until the owner's rsp ready; both request readys stay low from grant to response handshake.
module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter int OPW        = 5,
  parameter int FIXED_PRIO = 0,
  parameter int CNTW       = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_y,
  output logic             rsp0_zero,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_y,
  output logic             rsp1_zero,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,

  output logic [CNTW-1:0]  ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   win1;
  logic   owner_rsp_ready;

  // Port 1 wins when alone, or on a tie under round-robin when port 0 had the last grant.
  assign win1 = req1_valid && (!req0_valid || (FIXED_PRIO == 0 && !last_grant));

  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !win1;
  assign req1_ready = rst_n && (state == IDLE) && win1;

  assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp0_valid <= 1'b0;
      rsp0_y     <= '0;
      rsp0_zero  <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_y     <= '0;
      rsp1_zero  <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            alu_a      <= win1 ? req1_a  : req0_a;
            alu_b      <= win1 ? req1_b  : req0_b;
            alu_op     <= win1 ? req1_op : req0_op;
            owner      <= win1;
            last_grant <= win1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // ALU output settles from the operand registers within this cycle.
          if (owner) begin
            rsp1_y     <= alu_y;
            rsp1_zero  <= alu_zero;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_y     <= alu_y;
            rsp0_zero  <= alu_zero;
            rsp0_valid <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            ops_done   <= ops_done + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level model of grants and responses.
// A narrow op counter is used so that the wrap-around is reached within a short run.
module tb_alu_arbiter;
  localparam int WIDTH      = 32;
  localparam int OPW        = 5;
  localparam int FIXED_PRIO = 0;
  localparam int CNTW       = 8;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPW-1:0] OP_SUB  = 5'b10000;
  localparam logic [OPW-1:0] OP_AND  = 5'b00111;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01000;
  localparam logic [OPW-1:0] OP_SLLI = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [1:0]       v, rdy, rv, rr, rz;
  logic [WIDTH-1:0] a  [2];
  logic [WIDTH-1:0] b  [2];
  logic [OPW-1:0]   op [2];
  logic [WIDTH-1:0] ry0, ry1;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [OPW-1:0]   alu_op;
  logic             alu_zero;
  logic [CNTW-1:0]  ops_done;

  logic [OPW-1:0] opc [6] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_SLLI};

  // External ALU behaviour; unknown opcodes fall back to ADD.
  function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic [OPW-1:0] o);
    case (o)
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_MUL:  return x * y;
      OP_SLLI: return x << y[4:0];
      default: return x + y;
    endcase
  endfunction

  assign alu_y    = alu_ref(alu_a, alu_b, alu_op);
  assign alu_zero = (alu_y == '0);

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .FIXED_PRIO(FIXED_PRIO), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req0_ready(rdy[0]), .req0_a(a[0]), .req0_b(b[0]), .req0_op(op[0]),
    .req1_valid(v[1]), .req1_ready(rdy[1]), .req1_a(a[1]), .req1_b(b[1]), .req1_op(op[1]),
    .rsp0_valid(rv[0]), .rsp0_ready(rr[0]), .rsp0_y(ry0), .rsp0_zero(rz[0]),
    .rsp1_valid(rv[1]), .rsp1_ready(rr[1]), .rsp1_y(ry1), .rsp1_zero(rz[1]),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_zero(alu_zero),
    .ops_done(ops_done)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: one op outstanding, owner, grant cycle, expected result.
  bit               busy = 0, owner = 0, last = 1, keep = 0;
  int               cyc = 0, gcyc = 0, ops = 0;
  logic [WIDTH-1:0] ea, eb, ey;
  logic [OPW-1:0]   eop;
  logic [WIDTH-1:0] hold_y [2] = '{'0, '0};
  logic             hold_z [2] = '{1'b0, 1'b0};
  logic [1:0]       hs, rhs, seen_rdy, seen_rv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    int w;
    bit rvx;
    @(negedge clk);
    hs = '0; rhs = '0; seen_rdy = rdy; seen_rv = rv;
    if (rst_n) begin
      w = -1;
      if (!busy) begin
        if (v[0] && v[1]) w = (FIXED_PRIO != 0) ? 0 : (last ? 0 : 1);
        else if (v[0])    w = 0;
        else if (v[1])    w = 1;
      end
      chk("req0_ready", rdy[0], w == 0);
      chk("req1_ready", rdy[1], w == 1);
      rvx = busy && (cyc >= gcyc + 2);
      chk("rsp0_valid", rv[0], rvx && !owner);
      chk("rsp1_valid", rv[1], rvx && owner);
      if (rvx) begin
        chk("rsp_y", owner ? ry1 : ry0, ey);
        chk("rsp_zero", owner ? rz[1] : rz[0], ey == '0);
      end
      if (!busy) begin
        chk("hold_y0", ry0, hold_y[0]);
        chk("hold_y1", ry1, hold_y[1]);
        chk("hold_z0", rz[0], hold_z[0]);
        chk("hold_z1", rz[1], hold_z[1]);
      end else begin
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_op", alu_op, eop);
      end
      chk("ops_done", ops_done, ops % (1 << CNTW));
      if (w >= 0) begin
        hs[w] = 1'b1;
        ea = a[w]; eb = b[w]; eop = op[w];
        ey = alu_ref(ea, eb, eop);
      end
      if (rvx && rr[owner]) rhs[owner] = 1'b1;
    end
    @(posedge clk);
    if (!rst_n) begin
      busy = 0; last = 1; ops = 0;
      hold_y = '{'0, '0}; hold_z = '{1'b0, 1'b0};
    end else if (rhs != '0) begin
      busy = 0; ops++;
      hold_y[owner] = ey; hold_z[owner] = (ey == '0);
    end else if (hs != '0) begin
      busy = 1; owner = hs[1]; last = hs[1]; gcyc = cyc;
    end
    cyc++;
    #1;
    if (!keep) begin
      for (int p = 0; p < 2; p++) if (hs[p]) v[p] = 1'b0;
    end
  endtask

  task automatic set_req(input int p, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [OPW-1:0] o);
    v[p] = 1'b1; a[p] = x; b[p] = y; op[p] = o;
  endtask

  task automatic rand_req(input int p);
    logic [WIDTH-1:0] x, y;
    int k;
    x = ($urandom_range(0, 1) == 0) ? $urandom : WIDTH'($urandom_range(0, 3));
    y = ($urandom_range(0, 3) == 0) ? x : $urandom;
    k = $urandom_range(0, 6);
    set_req(p, x, y, (k < 6) ? opc[k] : OPW'($urandom));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((busy || v != '0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", busy || v != '0, 0);
  endtask

  initial begin
    int k, n, n1, prevc;
    v = '0; rr = '0;
    a = '{'0, '0}; b = '{'0, '0}; op = '{'0, '0};

    // Reset: everything zero.
    do_reset(2);
    chk("rst_req_ready", rdy, 0);
    chk("rst_rsp_valid", rv, 0);
    chk("rst_rsp0_y", ry0, 0);
    chk("rst_rsp1_y", ry1, 0);
    chk("rst_rsp_zero", rz, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_ops_done", ops_done, 0);

    // Single SUB on port 0, result two cycles after grant.
    set_req(0, 5, 3, OP_SUB);
    tick();
    chk("t2_grant", seen_rdy, 2'b01);
    tick();
    chk("t2_exec_no_valid", seen_rv, 2'b00);
    rr[0] = 1'b1;
    tick();
    chk("t2_rsp_valid", seen_rv, 2'b01);
    chk("t2_y", ry0, 2);
    chk("t2_zero", rz[0], 0);
    chk("t2_ops_done", ops_done, 1);

    // Zero result on port 1; port 0 response stays quiet.
    rr = 2'b11;
    set_req(1, 7, 7, OP_SUB);
    n = 0;
    repeat (5) begin tick(); n += int'(seen_rv[0]); end
    chk("t3_rsp0_quiet", n, 0);
    chk("t3_y1", ry1, 0);
    chk("t3_zero1", rz[1], 1);

    // Continuous contention from reset: strict alternation, one grant per 3 cycles.
    do_reset(1);
    keep = 1; rr = 2'b11;
    set_req(0, 2, 3, OP_MUL);
    set_req(1, 1, 4, OP_SLLI);
    k = 0; prevc = 0;
    repeat (24) begin
      tick();
      if (seen_rdy != '0) begin
        chk("t4_order", seen_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
        if (k > 0) chk("t4_gap", cyc - prevc, 3);
        prevc = cyc; k++;
      end
    end
    chk("t4_grants", k, 8);
    keep = 0; v = '0;
    drain(10);
    chk("t4_y0", ry0, 6);
    chk("t4_y1", ry1, 16);

    // Response backpressure on port 0 while port 1 waits.
    rr = 2'b00;
    set_req(0, 9, 4, OP_ADD);
    tick();
    set_req(1, 3, 3, OP_OR);
    n = 0; n1 = 0;
    repeat (12) begin tick(); n += int'(seen_rv[0]); n1 += int'(seen_rdy[1]); end
    chk("t5_valid_held", n, 11);
    chk("t5_req1_blocked", n1, 0);
    rr = 2'b11;
    drain(20);
    chk("t5_y0", ry0, 13);

    // Reset while a response is pending.
    rr = 2'b00;
    set_req(0, 4, 4, OP_AND);
    tick(); tick(); tick();
    chk("t6_pending", seen_rv, 2'b01);
    set_req(1, 1, 1, OP_ADD);
    do_reset(1);
    chk("t6_rsp0_valid", rv[0], 0);
    chk("t6_ops_done", ops_done, 0);
    set_req(0, 8, 1, OP_SUB);
    tick();
    chk("t6_tie_port0", seen_rdy, 2'b01);
    rr = 2'b11;
    drain(20);

    // Run until the op counter wraps back to zero.
    n = 0;
    while (ops < (1 << CNTW) && n < 4000) begin
      for (int p = 0; p < 2; p++) if (!v[p]) rand_req(p);
      tick();
      n++;
    end
    chk("wrap_ops_done", ops_done, ops % (1 << CNTW));
    chk("wrap_zero", ops_done, 0);

    // Random traffic with random response backpressure and abandoned requests.
    repeat (3000) begin
      for (int p = 0; p < 2; p++) begin
        if (!v[p]) begin
          if ($urandom_range(0, 99) < 45) rand_req(p);
        end else if ($urandom_range(0, 99) < 3) begin
          v[p] = 1'b0;
        end
      end
      rr = 2'($urandom_range(0, 3));
      tick();
    end
    v = '0; rr = 2'b11;
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
